// File: rtl/rvsteel_run_controller.sv
`default_nettype none
// ============================================================================
// Module  : rvsteel_run_controller
// Brief   : Sequences SoC reset, watches the bus for a tohost halt write,
//           runs a cycle watchdog and reports pass/fail/timeout.
//           Optional: RVSTEEL_RUN_CONTROLLER_AUTOSTART_EN (start once after reset).
// Revision: 1.0 - initial release
// ============================================================================
module rvsteel_run_controller #(
    parameter int          RESET_CYCLES   = 10,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [31:0] HALT_ADDRESS   = 32'h0000_1ffc,
    parameter int          COUNT_WIDTH    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   dut_reset,
    input  logic                   write_request,
    input  logic [31:0]            write_address,
    input  logic [31:0]            write_data,
    input  logic [3:0]             write_strobe,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [31:0]            fail_code,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int HOLD_WIDTH     = $clog2(RESET_CYCLES + 1);
    localparam int WATCHDOG_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [HOLD_WIDTH-1:0]     HOLD_LAST     = HOLD_WIDTH'(RESET_CYCLES);
    localparam logic [WATCHDOG_WIDTH-1:0] WATCHDOG_LAST = WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    state_t                    state_next;
    logic [HOLD_WIDTH-1:0]     hold_count;
    logic [WATCHDOG_WIDTH-1:0] watchdog;
    logic                      start_request;
    logic                      hold_done;
    logic                      halt;
    logic                      expire;

`ifdef RVSTEEL_RUN_CONTROLLER_AUTOSTART_EN
    // One-shot: high only for the first clock after reset release.
    logic auto_pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            auto_pending <= 1'b1;
        end else begin
            auto_pending <= 1'b0;
        end
    end

    assign start_request = start | auto_pending;
`else
    assign start_request = start;
`endif

    assign hold_done = (hold_count == HOLD_LAST);
    assign halt      = write_request && (write_address == HALT_ADDRESS)
                       && (write_strobe == 4'b1111);
    assign expire    = (watchdog == WATCHDOG_LAST);

    assign busy = (state == HOLD) || (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_request) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt || expire) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // dut_reset tracks the next state so it drops exactly on the first RUN cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dut_reset   <= 1'b1;
            hold_count  <= '0;
            watchdog    <= '0;
            cycle_count <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
        end else begin
            dut_reset <= (state_next != RUN);
            case (state)
                IDLE, DONE: begin
                    if (start_request) begin
                        hold_count  <= '0;
                        watchdog    <= '0;
                        cycle_count <= '0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        fail_code   <= '0;
                    end
                end
                HOLD: begin
                    if (!hold_done) begin
                        hold_count <= hold_count + 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_count != {COUNT_WIDTH{1'b1}}) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (!expire) begin
                        watchdog <= watchdog + 1'b1;
                    end
                    // A halt in the same cycle as watchdog expiry takes priority.
                    if (halt) begin
                        pass      <= (write_data == 32'd1);
                        fail_code <= (write_data == 32'd1) ? 32'd0 : {1'b0, write_data[31:1]};
                    end else if (expire) begin
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvsteel_run_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvsteel_run_controller
// Brief   : Scoreboard bench for rvsteel_run_controller (two configurations).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rvsteel_run_controller;

    localparam logic [31:0] HALT = 32'h0000_1ffc;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        write_request = 1'b0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_strobe = '0;

    logic        dut_reset_a, busy_a, done_a, pass_a, timeout_a;
    logic [31:0] fail_code_a, cycle_count_a;
    logic        dut_reset_b, busy_b, done_b, pass_b, timeout_b;
    logic [31:0] fail_code_b;
    logic [3:0]  cycle_count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    rvsteel_run_controller #(
        .RESET_CYCLES(10), .TIMEOUT_CYCLES(100), .HALT_ADDRESS(HALT), .COUNT_WIDTH(32)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .dut_reset(dut_reset_a),
        .write_request(write_request), .write_address(write_address),
        .write_data(write_data), .write_strobe(write_strobe),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
        .fail_code(fail_code_a), .cycle_count(cycle_count_a)
    );

    rvsteel_run_controller #(
        .RESET_CYCLES(3), .TIMEOUT_CYCLES(40), .HALT_ADDRESS(HALT), .COUNT_WIDTH(4)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .dut_reset(dut_reset_b),
        .write_request(write_request), .write_address(write_address),
        .write_data(write_data), .write_strobe(write_strobe),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
        .fail_code(fail_code_b), .cycle_count(cycle_count_b)
    );

    typedef struct packed {
        logic        dut_reset;
        logic        busy;
        logic        done;
        logic        pass;
        logic        timeout;
        logic [31:0] fail_code;
        logic [31:0] cycle_count;
    } obs_t;

    typedef struct {
        string       tag;
        bit          sel;
        logic        pass;
        logic        timeout;
        logic [31:0] fail_code;
        logic [31:0] cycle_count;
    } exp_t;

    exp_t sb_q[$];

    function automatic obs_t observe(input bit sel);
        obs_t o;
        if (sel) o = '{dut_reset_b, busy_b, done_b, pass_b, timeout_b, fail_code_b, 32'(cycle_count_b)};
        else     o = '{dut_reset_a, busy_a, done_a, pass_a, timeout_a, fail_code_a, cycle_count_a};
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_result(input string tag, input bit sel, input logic p, input logic t,
                                 input logic [31:0] fc, input logic [31:0] cc);
        exp_t e;
        e.tag = tag; e.sel = sel; e.pass = p; e.timeout = t; e.fail_code = fc; e.cycle_count = cc;
        sb_q.push_back(e);
    endtask

    // Pulse start and verify dut_reset deasserts exactly exp_edges edges after sampling.
    task automatic start_run(input bit sel, input int exp_edges, input string tag);
        int k;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
        for (k = 1; k <= 64; k++) begin
            tick(1);
            if (!observe(sel).dut_reset) break;
        end
        check({tag, "_release_edges"}, k, exp_edges);
        check({tag, "_busy"}, observe(sel).busy, 1'b1);
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        write_request = 1'b1;
        write_address = addr;
        write_data    = data;
        write_strobe  = strb;
        tick(1);
        write_request = 1'b0;
        write_address = '0;
        write_data    = '0;
        write_strobe  = '0;
    endtask

    task automatic wait_done(input bit sel, input int bound);
        exp_t e;
        obs_t o;
        for (int i = 0; i < bound && !observe(sel).done; i++) tick(1);
        o = observe(sel);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_done"}, o.done, 1'b1);
            check({e.tag, "_pass"}, o.pass, e.pass);
            check({e.tag, "_timeout"}, o.timeout, e.timeout);
            check({e.tag, "_fail_code"}, o.fail_code, e.fail_code);
            check({e.tag, "_cycle_count"}, o.cycle_count, e.cycle_count);
            check({e.tag, "_dut_reset"}, o.dut_reset, 1'b1);
            check({e.tag, "_busy"}, o.busy, 1'b0);
        end
    endtask

    initial begin
        obs_t o;
        tick(3);
        o = observe(1'b0);
        check("rst_dut_reset", o.dut_reset, 1'b1);
        check("rst_busy", o.busy, 1'b0);
        check("rst_done", o.done, 1'b0);
        check("rst_flags", {o.pass, o.timeout}, 2'b00);
        check("rst_fail_code", o.fail_code, 32'd0);
        check("rst_cycle_count", o.cycle_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick(1);
`ifdef RVSTEEL_RUN_CONTROLLER_AUTOSTART_EN
        check("autostart_busy", busy_a, 1'b1);
        for (int i = 0; i < 200 && !(done_a && done_b); i++) tick(1);
        check("autostart_finished", {done_a, done_b}, 2'b11);
`else
        tick(3);
        check("idle_stays", {busy_a, busy_b, dut_reset_a}, 3'b001);
`endif

        // Passing halt in RUN cycle 50.
        start_run(1'b0, 11, "pass50");
        tick(49);
        expect_result("pass50", 1'b0, 1'b1, 1'b0, 32'd0, 32'd50);
        drive_write(HALT, 32'd1, 4'b1111);
        wait_done(1'b0, 0);
        tick(5);
        check("done_frozen_count", cycle_count_a, 32'd50);
        check("done_held", {done_a, dut_reset_a}, 2'b11);

        // Partial strobe and wrong address ignored, then failing halt in cycle 19.
        start_run(1'b0, 11, "fail7");
        tick(4);
        drive_write(HALT, 32'd1, 4'b0001);
        drive_write(HALT + 32'd4, 32'd1, 4'b1111);
        check("partial_ignored", {done_a, busy_a, dut_reset_a}, 3'b010);
        tick(12);
        expect_result("fail7", 1'b0, 1'b0, 1'b0, 32'd3, 32'd19);
        drive_write(HALT, 32'd7, 4'b1111);
        wait_done(1'b0, 0);

        // Watchdog expiry after exactly 100 RUN cycles.
        start_run(1'b0, 11, "tmo");
        expect_result("tmo", 1'b0, 1'b0, 1'b1, 32'd0, 32'd100);
        tick(99);
        check("no_early_timeout", done_a, 1'b0);
        tick(1);
        wait_done(1'b0, 0);

        // Halt in the same cycle as expiry wins.
        start_run(1'b0, 11, "race");
        tick(99);
        expect_result("race", 1'b0, 1'b1, 1'b0, 32'd0, 32'd100);
        drive_write(HALT, 32'd1, 4'b1111);
        wait_done(1'b0, 0);

        // Narrow counter saturates while the watchdog still runs to 40.
        start_run(1'b1, 4, "sat");
        expect_result("sat", 1'b1, 1'b0, 1'b1, 32'd0, 32'd15);
        wait_done(1'b1, 60);

        // Asynchronous reset in the middle of a run.
        start_run(1'b0, 11, "midrst");
        tick(10);
        reset = 1'b0;
        #1;
        o = observe(1'b0);
        check("midrst_dut_reset", o.dut_reset, 1'b1);
        check("midrst_state", {o.busy, o.done}, 2'b00);
        check("midrst_cycle_count", o.cycle_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick(1);
`ifdef RVSTEEL_RUN_CONTROLLER_AUTOSTART_EN
        check("midrst_autostart", {busy_a, dut_reset_a}, 2'b11);
`else
        check("midrst_idle", {busy_a, dut_reset_a}, 2'b01);
        tick(3);
        check("midrst_idle_later", {busy_a, done_a}, 2'b00);
`endif

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
